// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   start, op, a, b            : request side, driven by the requester
//   busy, done                 : status; done is a one-cycle result-valid pulse
//   result, result_hi          : low word / MUL high word (0 for other ops)
//   flag_z, flag_n, flag_c, flag_v : zero, negative, carry/borrow, signed overflow
interface seq_alu_if #(
  parameter int NBITS = 8
);
  logic             start;
  logic [2:0]       op;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;
  logic [NBITS-1:0] result_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU. Logic/add/sub/SLT complete in one cycle; MUL is a
// radix-2 shift-add over NBITS iterations (the first iteration is folded into
// the accepting edge so start-to-done latency is NBITS cycles).
//   clk_2 : clock, rising edge
//   reset : synchronous, active-high
//   bus   : seq_alu_if slave (start/op/a/b in; busy/done/result/result_hi/flags out)
module seq_alu #(
  parameter int NBITS = 8
) (
  input  logic      clk_2,
  input  logic      reset,
  seq_alu_if.slave  bus
);

  localparam int CNT_W = (NBITS > 2) ? $clog2(NBITS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // {carry, overflow, result}
  function automatic logic [NBITS+1:0] alu_op(input logic [2:0] op,
                                              input logic [NBITS-1:0] a,
                                              input logic [NBITS-1:0] b);
    logic [NBITS:0]   s;
    logic [NBITS-1:0] r;
    logic             c;
    logic             v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[NBITS-1:0];
        c = s[NBITS];
        v = (a[NBITS-1] == b[NBITS-1]) && (r[NBITS-1] != a[NBITS-1]);
      end
      3'b011: r = ($signed(a) < $signed(b)) ? NBITS'(1) : '0;
      3'b100: r = a & ~b;
      3'b101: r = a | ~b;
      3'b110: begin
        // Bit NBITS of the widened difference is the borrow.
        s = {1'b0, a} - {1'b0, b};
        r = s[NBITS-1:0];
        c = s[NBITS];
        v = (a[NBITS-1] != b[NBITS-1]) && (r[NBITS-1] != a[NBITS-1]);
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // One shift-add step on the {hi, lo} product register; lo holds the
  // not-yet-consumed multiplier bits, so lo[0] is the current bit.
  function automatic logic [2*NBITS-1:0] mul_step(input logic [NBITS-1:0] hi,
                                                  input logic [NBITS-1:0] lo,
                                                  input logic [NBITS-1:0] mcand);
    logic [NBITS:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    return {s, lo[NBITS-1:1]};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   acc_q, acc_d;
  logic [NBITS-1:0]   mpl_q, mpl_d;
  logic [NBITS-1:0]   mcand_q, mcand_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic [NBITS-1:0]   result_hi_q, result_hi_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic               done_q, done_d;

  logic [NBITS+1:0]   alu_res;
  logic [2*NBITS-1:0] step;
  logic               in_mul;

  assign in_mul  = (state_q == S_MUL);
  assign alu_res = alu_op(bus.op, bus.a, bus.b);
  // In IDLE the step works straight off the inputs (first MUL iteration).
  assign step    = mul_step(in_mul ? acc_q : '0,
                            in_mul ? mpl_q : bus.b,
                            in_mul ? mcand_q : bus.a);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mpl_d       = mpl_q;
    mcand_d     = mcand_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == 3'b111) begin
            state_d = S_MUL;
            acc_d   = step[2*NBITS-1:NBITS];
            mpl_d   = step[NBITS-1:0];
            mcand_d = bus.a;
            cnt_d   = CNT_W'(1);
          end else begin
            result_d    = alu_res[NBITS-1:0];
            result_hi_d = '0;
            c_d         = alu_res[NBITS+1];
            v_d         = alu_res[NBITS];
            z_d         = (alu_res[NBITS-1:0] == '0);
            n_d         = alu_res[NBITS-1];
            done_d      = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = step[2*NBITS-1:NBITS];
        mpl_d = step[NBITS-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NBITS - 1)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          result_d    = step[NBITS-1:0];
          result_hi_d = step[2*NBITS-1:NBITS];
          c_d         = (step[2*NBITS-1:NBITS] != '0);
          v_d         = 1'b0;
          z_d         = (step[NBITS-1:0] == '0);
          n_d         = step[NBITS-1];
          done_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible outputs: cleared by reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      done_q      <= done_d;
    end
  end

  // Multiplier working registers: only meaningful while in MUL.
  always_ff @(posedge clk_2) begin
    acc_q   <= acc_d;
    mpl_q   <= mpl_d;
    mcand_q <= mcand_d;
  end

  assign bus.busy      = in_mul;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;

endmodule
